// File: rtl/pac_catch_ctrl_pkg.sv
// Shared types and defaults for the Pac-Man catch/lives controller and its
// position-overlap helper.
package pac_catch_ctrl_pkg;

    // Coordinate and lives widths used across the actor interface.
    localparam int COORD_W = 9;
    localparam int LIVES_W = 3;

    // Default tuning for the red ghost.
    localparam int GHOST_COLLIDE_DIST    = 4;
    localparam int FREEZE_FRAMES_DEFAULT = 60;
    localparam int INIT_LIVES_DEFAULT    = 3;

    typedef logic [COORD_W-1:0] coord_t;
    typedef logic [LIVES_W-1:0] lives_t;

    // Game flow states.
    typedef enum logic [1:0] {
        PLAY      = 2'd0,
        CAUGHT    = 2'd1,
        RESPAWN   = 2'd2,
        GAME_OVER = 2'd3
    } game_state_t;

endpackage

// File: rtl/pac_catch_ctrl_if.sv
// Actor-position / game-status bundle between the movers (master side) and
// the catch controller (slave side).
interface pac_catch_ctrl_if;
    import pac_catch_ctrl_pkg::*;

    logic   frame_stb;
    logic   start_btn;
    coord_t x_pac;
    coord_t y_pac;
    coord_t x_red;
    coord_t y_red;
    logic   move_stb;
    logic   actor_rst;
    logic   caught;
    lives_t lives;
    logic   game_over;

    // Movers / top level: supply positions and strobes, consume game status.
    modport master (
        output frame_stb, start_btn, x_pac, y_pac, x_red, y_red,
        input  move_stb, actor_rst, caught, lives, game_over
    );

    // Catch controller: the opposite view.
    modport slave (
        input  frame_stb, start_btn, x_pac, y_pac, x_red, y_red,
        output move_stb, actor_rst, caught, lives, game_over
    );

endinterface

// File: rtl/pac_catch_ctrl_overlap.sv
// actor_overlap: purely combinational box test between two actors. Both
// axes must be strictly closer than COLLIDE_DIST pixels. Reused for pellet
// and extra-ghost checks.
module actor_overlap
    import pac_catch_ctrl_pkg::*;
#(
    parameter int COLLIDE_DIST = GHOST_COLLIDE_DIST
) (
    input  coord_t x_a,
    input  coord_t y_a,
    input  coord_t x_b,
    input  coord_t y_b,
    output logic   overlap
);

    localparam logic [COORD_W:0] DIST = COLLIDE_DIST[COORD_W:0];

    // Zero-extend both coordinates to a signed difference, then fold to a
    // magnitude; the range is -511..511 so negation never overflows.
    function automatic logic [COORD_W:0] abs_diff(input coord_t a, input coord_t b);
        logic signed [COORD_W:0] d;
        d = $signed({1'b0, a}) - $signed({1'b0, b});
        abs_diff = d[COORD_W] ? $unsigned(-d) : $unsigned(d);
    endfunction

    logic [COORD_W:0] dx_abs;
    logic [COORD_W:0] dy_abs;

    // Strict less-than on both axes.
    always_comb begin
        dx_abs  = abs_diff(x_a, x_b);
        dy_abs  = abs_diff(y_a, y_b);
        overlap = (dx_abs < DIST) && (dy_abs < DIST);
    end

endmodule

// File: rtl/pac_catch_ctrl.sv
// pac_catch_ctrl: decides when the red ghost catches Pac-Man, owns the lives
// counter and the play / caught / respawn / game-over flow, and feeds the
// movers their step strobe and a one-cycle respawn reset.
module pac_catch_ctrl
    import pac_catch_ctrl_pkg::*;
#(
    parameter int INIT_LIVES    = INIT_LIVES_DEFAULT,
    parameter int COLLIDE_DIST  = GHOST_COLLIDE_DIST,
    parameter int FREEZE_FRAMES = FREEZE_FRAMES_DEFAULT
) (
    input  logic             vga_pix_clk,
    input  logic             rst,
    pac_catch_ctrl_if.slave  bus
);

    localparam int CNT_W = $clog2(FREEZE_FRAMES + 1);
    localparam logic [CNT_W-1:0] FREEZE_LOAD = CNT_W'(FREEZE_FRAMES);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
    localparam lives_t           LIVES_LOAD  = LIVES_W'(INIT_LIVES);
    localparam lives_t           LIVES_ONE   = LIVES_W'(1);

    game_state_t      state_q, state_d;
    lives_t           lives_q, lives_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             caught_q, caught_d;
    logic             actor_rst_q, actor_rst_d;
    logic             game_over_q, game_over_d;
    logic             overlap;

    actor_overlap #(
        .COLLIDE_DIST (COLLIDE_DIST)
    ) u_red_overlap (
        .x_a     (bus.x_pac),
        .y_a     (bus.y_pac),
        .x_b     (bus.x_red),
        .y_b     (bus.y_red),
        .overlap (overlap)
    );

    // Next-state logic: catch detection in PLAY, frame-counted freeze,
    // single-cycle respawn and restart from game over.
    always_comb begin
        state_d  = state_q;
        lives_d  = lives_q;
        cnt_d    = cnt_q;
        caught_d = 1'b0;
        unique case (state_q)
            PLAY: begin
                if (bus.frame_stb && overlap) begin
                    state_d  = CAUGHT;
                    caught_d = 1'b1;
                    lives_d  = lives_q - LIVES_ONE;
                    cnt_d    = FREEZE_LOAD;
                end
            end
            CAUGHT: begin
                if (bus.frame_stb) begin
                    if (cnt_q == CNT_ONE) begin
                        state_d = (lives_q == '0) ? GAME_OVER : RESPAWN;
                    end else begin
                        cnt_d = cnt_q - CNT_ONE;
                    end
                end
            end
            RESPAWN: begin
                state_d = PLAY;
            end
            GAME_OVER: begin
                if (bus.start_btn) begin
                    lives_d = LIVES_LOAD;
                    state_d = RESPAWN;
                end
            end
            default: begin
                state_d = RESPAWN;
            end
        endcase
        // Status outputs are registered views of the state being entered.
        actor_rst_d = (state_d == RESPAWN);
        game_over_d = (state_d == GAME_OVER);
    end

    // State and registered outputs; reset lands in RESPAWN so the movers get
    // their spawn reset straight away.
    always_ff @(posedge vga_pix_clk) begin
        if (rst) begin
            state_q     <= RESPAWN;
            lives_q     <= LIVES_LOAD;
            cnt_q       <= '0;
            caught_q    <= 1'b0;
            actor_rst_q <= 1'b1;
            game_over_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            lives_q     <= lives_d;
            cnt_q       <= cnt_d;
            caught_q    <= caught_d;
            actor_rst_q <= actor_rst_d;
            game_over_q <= game_over_d;
        end
    end

    // Movers step only while playing; the catching frame still steps.
    assign bus.move_stb  = bus.frame_stb && (state_q == PLAY);
    assign bus.actor_rst = actor_rst_q;
    assign bus.caught    = caught_q;
    assign bus.lives     = lives_q;
    assign bus.game_over = game_over_q;

endmodule

// File: tb/tb_pac_catch_ctrl.sv
// Bench for pac_catch_ctrl: directed scenarios followed by a randomized run
// checked against a behavioural model of the game rules.
module tb_pac_catch_ctrl;
    import pac_catch_ctrl_pkg::*;

    localparam int INIT_L = 3;
    localparam int DIST   = 4;
    localparam int FREEZE = 60;

    localparam int MODE_PLAY   = 0;
    localparam int MODE_FROZEN = 1;
    localparam int MODE_RESPWN = 2;
    localparam int MODE_OVER   = 3;

    logic clk = 1'b0;
    logic rst = 1'b0;

    pac_catch_ctrl_if bus();

    pac_catch_ctrl #(
        .INIT_LIVES    (INIT_L),
        .COLLIDE_DIST  (DIST),
        .FREEZE_FRAMES (FREEZE)
    ) dut (
        .vga_pix_clk (clk),
        .rst         (rst),
        .bus         (bus)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    // Behavioural model: game mode, lives left, frames of freeze still to go.
    int m_mode  = MODE_RESPWN;
    int m_lives = INIT_L;
    int m_left  = 0;
    bit m_caught = 1'b0;
    bit m_arst   = 1'b1;

    function automatic bit near(input int xa, input int ya, input int xb, input int yb);
        int ax;
        int ay;
        ax = (xa > xb) ? xa - xb : xb - xa;
        ay = (ya > yb) ? ya - yb : yb - ya;
        return (ax < DIST) && (ay < DIST);
    endfunction

    function automatic logic [8:0] clamp9(input int v);
        int c;
        c = (v < 0) ? 0 : ((v > 511) ? 511 : v);
        return c[8:0];
    endfunction

    // Apply the game rules for one clock edge using the inputs present now.
    task automatic model_edge();
        bit hit;
        hit = near(int'(bus.x_pac), int'(bus.y_pac), int'(bus.x_red), int'(bus.y_red));
        m_caught = 1'b0;
        if (rst) begin
            m_mode  = MODE_RESPWN;
            m_lives = INIT_L;
            m_left  = 0;
        end else if (m_mode == MODE_PLAY) begin
            if (bus.frame_stb && hit) begin
                m_mode   = MODE_FROZEN;
                m_caught = 1'b1;
                m_lives  = m_lives - 1;
                m_left   = FREEZE;
            end
        end else if (m_mode == MODE_FROZEN) begin
            if (bus.frame_stb) begin
                m_left = m_left - 1;
                if (m_left == 0) m_mode = (m_lives == 0) ? MODE_OVER : MODE_RESPWN;
            end
        end else if (m_mode == MODE_RESPWN) begin
            m_mode = MODE_PLAY;
        end else begin
            if (bus.start_btn) begin
                m_lives = INIT_L;
                m_mode  = MODE_RESPWN;
            end
        end
        m_arst = (m_mode == MODE_RESPWN);
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic set_pos(input int xp, input int yp, input int xr, input int yr);
        bus.x_pac = clamp9(xp);
        bus.y_pac = clamp9(yp);
        bus.x_red = clamp9(xr);
        bus.y_red = clamp9(yr);
    endtask

    task automatic frame();
        bus.frame_stb = 1'b1;
        tick();
        bus.frame_stb = 1'b0;
    endtask

    // Run the full freeze, counting any move strobe, caught pulse, or early
    // respawn / game-over seen before the last freeze frame.
    task automatic freeze_through(output int bad);
        bad = 0;
        for (int i = 0; i < FREEZE; i++) begin
            bus.frame_stb = 1'b1;
            #1;
            if (bus.move_stb !== 1'b0) bad++;
            tick();
            bus.frame_stb = 1'b0;
            if (bus.caught !== 1'b0) bad++;
            if (i < FREEZE - 1) begin
                if (bus.actor_rst !== 1'b0 || bus.game_over !== 1'b0) bad++;
                tick();
                tick();
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_total++;
        if (bus.actor_rst !== 1'b1) $display("FAIL reset_actor_rst got=%b exp=1", bus.actor_rst); else n_pass++;
        n_total++;
        if (bus.lives !== 3'd3) $display("FAIL reset_lives got=%0d exp=3", bus.lives); else n_pass++;
        n_total++;
        if (bus.game_over !== 1'b0 || bus.caught !== 1'b0)
            $display("FAIL reset_flags got go=%b caught=%b exp=0/0", bus.game_over, bus.caught);
        else n_pass++;
        bus.frame_stb = 1'b1;
        #1;
        n_total++;
        if (bus.move_stb !== 1'b0) $display("FAIL respawn_move_stb got=%b exp=0", bus.move_stb); else n_pass++;
        tick();
        bus.frame_stb = 1'b0;
        n_total++;
        if (bus.actor_rst !== 1'b0) $display("FAIL reset_actor_rst_drop got=%b exp=0", bus.actor_rst); else n_pass++;
        bus.frame_stb = 1'b1;
        #1;
        n_total++;
        if (bus.move_stb !== 1'b1) $display("FAIL play_move_stb_hi got=%b exp=1", bus.move_stb); else n_pass++;
        bus.frame_stb = 1'b0;
        #1;
        n_total++;
        if (bus.move_stb !== 1'b0) $display("FAIL play_move_stb_lo got=%b exp=0", bus.move_stb); else n_pass++;
    endtask

    task automatic test_catch();
        int bad;
        set_pos(100, 100, 103, 97);
        bus.frame_stb = 1'b1;
        #1;
        n_total++;
        if (bus.move_stb !== 1'b1) $display("FAIL catch_last_step got=%b exp=1", bus.move_stb); else n_pass++;
        tick();
        bus.frame_stb = 1'b0;
        n_total++;
        if (bus.caught !== 1'b1) $display("FAIL catch_pulse got=%b exp=1", bus.caught); else n_pass++;
        n_total++;
        if (bus.lives !== 3'd2) $display("FAIL catch_lives got=%0d exp=2", bus.lives); else n_pass++;
        tick();
        n_total++;
        if (bus.caught !== 1'b0) $display("FAIL catch_pulse_width got=%b exp=0", bus.caught); else n_pass++;
        freeze_through(bad);
        n_total++;
        if (bad != 0) $display("FAIL catch_freeze got=%0d anomalies exp=0", bad); else n_pass++;
        n_total++;
        if (bus.actor_rst !== 1'b1) $display("FAIL catch_respawn got=%b exp=1", bus.actor_rst); else n_pass++;
        set_pos(10, 10, 200, 200);
        tick();
        n_total++;
        if (bus.actor_rst !== 1'b0) $display("FAIL catch_respawn_width got=%b exp=0", bus.actor_rst); else n_pass++;
        bus.frame_stb = 1'b1;
        #1;
        n_total++;
        if (bus.move_stb !== 1'b1) $display("FAIL catch_back_to_play got=%b exp=1", bus.move_stb); else n_pass++;
        bus.frame_stb = 1'b0;
    endtask

    task automatic test_boundary();
        int bad;
        set_pos(100, 100, 104, 100);
        frame();
        n_total++;
        if (bus.caught !== 1'b0) $display("FAIL bound_plus4 got=%b exp=0", bus.caught); else n_pass++;
        set_pos(100, 100, 96, 100);
        frame();
        n_total++;
        if (bus.caught !== 1'b0) $display("FAIL bound_minus4 got=%b exp=0", bus.caught); else n_pass++;
        set_pos(100, 100, 97, 100);
        frame();
        n_total++;
        if (bus.caught !== 1'b1 || bus.lives !== 3'd1)
            $display("FAIL bound_minus3 got caught=%b lives=%0d exp=1/1", bus.caught, bus.lives);
        else n_pass++;
        tick();
        freeze_through(bad);
        n_total++;
        if (bad != 0 || bus.actor_rst !== 1'b1)
            $display("FAIL bound_freeze got=%0d/%b exp=0/1", bad, bus.actor_rst);
        else n_pass++;
        set_pos(10, 10, 200, 200);
        tick();
    endtask

    task automatic test_frame_gate();
        int hits;
        int bad;
        hits = 0;
        set_pos(50, 60, 52, 62);
        bus.frame_stb = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            tick();
            if (bus.caught !== 1'b0) hits++;
        end
        n_total++;
        if (hits != 0) $display("FAIL gate_no_frame got=%0d catches exp=0", hits); else n_pass++;
        frame();
        n_total++;
        if (bus.caught !== 1'b1 || bus.lives !== 3'd0)
            $display("FAIL gate_first_frame got caught=%b lives=%0d exp=1/0", bus.caught, bus.lives);
        else n_pass++;
        tick();
        freeze_through(bad);
        n_total++;
        if (bad != 0) $display("FAIL last_freeze got=%0d anomalies exp=0", bad); else n_pass++;
        n_total++;
        if (bus.game_over !== 1'b1 || bus.actor_rst !== 1'b0 || bus.lives !== 3'd0)
            $display("FAIL enter_game_over got go=%b arst=%b lives=%0d exp=1/0/0",
                     bus.game_over, bus.actor_rst, bus.lives);
        else n_pass++;
    endtask

    task automatic test_game_over();
        set_pos(10, 10, 200, 200);
        bus.frame_stb = 1'b1;
        #1;
        n_total++;
        if (bus.move_stb !== 1'b0) $display("FAIL over_move_stb got=%b exp=0", bus.move_stb); else n_pass++;
        tick();
        bus.frame_stb = 1'b0;
        n_total++;
        if (bus.game_over !== 1'b1 || bus.lives !== 3'd0)
            $display("FAIL over_hold got go=%b lives=%0d exp=1/0", bus.game_over, bus.lives);
        else n_pass++;
        bus.start_btn = 1'b1;
        tick();
        bus.start_btn = 1'b0;
        n_total++;
        if (bus.lives !== 3'd3 || bus.actor_rst !== 1'b1 || bus.game_over !== 1'b0)
            $display("FAIL restart got lives=%0d arst=%b go=%b exp=3/1/0",
                     bus.lives, bus.actor_rst, bus.game_over);
        else n_pass++;
        tick();
        n_total++;
        if (bus.actor_rst !== 1'b0) $display("FAIL restart_arst_width got=%b exp=0", bus.actor_rst); else n_pass++;
        bus.frame_stb = 1'b1;
        #1;
        n_total++;
        if (bus.move_stb !== 1'b1) $display("FAIL restart_play got=%b exp=1", bus.move_stb); else n_pass++;
        tick();
        bus.frame_stb = 1'b0;
    endtask

    task automatic test_reset_mid_freeze();
        int bad;
        set_pos(30, 30, 31, 29);
        frame();
        n_total++;
        if (bus.caught !== 1'b1 || bus.lives !== 3'd2)
            $display("FAIL midrst_catch got caught=%b lives=%0d exp=1/2", bus.caught, bus.lives);
        else n_pass++;
        tick();
        for (int i = 0; i < 30; i++) begin
            frame();
            tick();
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_total++;
        if (bus.lives !== 3'd3 || bus.actor_rst !== 1'b1 || bus.caught !== 1'b0 || bus.game_over !== 1'b0)
            $display("FAIL midrst_state got lives=%0d arst=%b caught=%b go=%b exp=3/1/0/0",
                     bus.lives, bus.actor_rst, bus.caught, bus.game_over);
        else n_pass++;
        set_pos(10, 10, 200, 200);
        tick();
        n_total++;
        if (bus.actor_rst !== 1'b0) $display("FAIL midrst_play got arst=%b exp=0", bus.actor_rst); else n_pass++;
        bad = 0;
        bus.start_btn = 1'b1;
        for (int i = 0; i < 20; i++) begin
            bus.frame_stb = i[0];
            tick();
            if (bus.caught !== 1'b0 || bus.actor_rst !== 1'b0 || bus.game_over !== 1'b0 || bus.lives !== 3'd3)
                bad++;
        end
        bus.start_btn = 1'b0;
        bus.frame_stb = 1'b0;
        n_total++;
        if (bad != 0) $display("FAIL start_in_play got=%0d anomalies exp=0", bad); else n_pass++;
    endtask

    task automatic test_random();
        int xp;
        int yp;
        bit exp_move;
        for (int i = 0; i < 4000; i++) begin
            xp = int'($urandom_range(0, 511));
            yp = int'($urandom_range(0, 511));
            if ($urandom_range(0, 3) == 0)
                set_pos(xp, yp, int'($urandom_range(0, 511)), int'($urandom_range(0, 511)));
            else
                set_pos(xp, yp, xp + int'($urandom_range(0, 12)) - 6, yp + int'($urandom_range(0, 12)) - 6);
            bus.frame_stb = ($urandom_range(0, 2) == 0);
            bus.start_btn = ($urandom_range(0, 7) == 0);
            rst = ($urandom_range(0, 299) == 0);
            #1;
            exp_move = bus.frame_stb && (m_mode == MODE_PLAY);
            n_total++;
            if (bus.move_stb !== exp_move)
                $display("FAIL rnd_move_stb cyc=%0d got=%b exp=%b", i, bus.move_stb, exp_move);
            else n_pass++;
            tick();
            n_total++;
            if (bus.caught !== m_caught)
                $display("FAIL rnd_caught cyc=%0d got=%b exp=%b", i, bus.caught, m_caught);
            else n_pass++;
            n_total++;
            if (bus.actor_rst !== m_arst)
                $display("FAIL rnd_actor_rst cyc=%0d got=%b exp=%b", i, bus.actor_rst, m_arst);
            else n_pass++;
            n_total++;
            if (bus.lives !== m_lives[2:0])
                $display("FAIL rnd_lives cyc=%0d got=%0d exp=%0d", i, bus.lives, m_lives);
            else n_pass++;
            n_total++;
            if (bus.game_over !== (m_mode == MODE_OVER))
                $display("FAIL rnd_game_over cyc=%0d got=%b exp=%b", i, bus.game_over, m_mode == MODE_OVER);
            else n_pass++;
        end
        rst = 1'b0;
        bus.frame_stb = 1'b0;
        bus.start_btn = 1'b0;
    endtask

    initial begin
        bus.frame_stb = 1'b0;
        bus.start_btn = 1'b0;
        set_pos(10, 10, 200, 200);
        test_reset();
        test_catch();
        test_boundary();
        test_frame_gate();
        test_game_over();
        test_reset_mid_freeze();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
